hub75_bcm_scheduler: RTL and testbench



---
 rtl/hub75_pkg.sv | 15 +
 rtl/hub75_tick_timer.sv | 33 +++
 rtl/hub75_bcm_scheduler.sv | 154 +++++++++++++++
 tb/tb_hub75_bcm_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 BCM scheduler.
package hub75_pkg;

    typedef enum logic [2:0] {IDLE, REQ, SHIFT, DEAD, LATCH, SHOW} sched_state_t;

    function automatic int plane_width(input int planes);
        return (planes > 1) ? $clog2(planes) : 1;
    endfunction

    // Wide enough to hold the longest SHOW interval, BASE_TICKS << (planes-1).
    function automatic int timer_width(input int base_ticks, input int planes);
        return $clog2(base_ticks << (planes - 1)) + 1;
    endfunction

endpackage

// File: rtl/hub75_tick_timer.sv
// Loadable down-counter; expire is high while the count sits at 1 (last tick of an interval).
module hub75_tick_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expire
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == WIDTH'(1));

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// BCM row/plane sequencer for a HUB75 panel: request row load, wait for shift,
// dead-time, latch, then unblank for BASE_TICKS << plane cycles.
module hub75_bcm_scheduler
    import hub75_pkg::*;
#(
    parameter int NUM_ROWS   = 32,
    parameter int ADDR_BITS  = 5,
    parameter int BIT_PLANES = 6,
    parameter int BASE_TICKS = 8,
    parameter int DEAD_TICKS = 2,
    localparam int PLANE_W   = plane_width(BIT_PLANES),
    localparam int TIMER_W   = timer_width(BASE_TICKS, BIT_PLANES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    output logic                 m_req_valid,
    input  logic                 m_req_ready,
    output logic [ADDR_BITS-1:0] m_row,
    output logic [PLANE_W-1:0]   m_plane,
    input  logic                 shift_done,
    output logic                 blank,
    output logic                 latch_out,
    output logic [ADDR_BITS-1:0] addr_out,
    output logic                 frame_done,
    output logic                 busy
);

    sched_state_t         state_q, state_d;
    logic [ADDR_BITS-1:0] row_q, row_d, addr_q, addr_d;
    logic [PLANE_W-1:0]   plane_q, plane_d;
    logic                 req_valid_q, req_valid_d;
    logic                 blank_q, blank_d;
    logic                 latch_q, latch_d;
    logic                 frame_done_q, frame_done_d;
    logic                 busy_q, busy_d;
    logic                 frame_end;
    logic                 tmr_load;
    logic [TIMER_W-1:0]   tmr_value;
    logic                 tmr_expire;
    logic                 last_plane, last_row;

    assign last_plane = (plane_q == PLANE_W'(BIT_PLANES - 1));
    assign last_row   = (row_q == ADDR_BITS'(NUM_ROWS - 1));

    hub75_tick_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (reset_n),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        plane_d   = plane_q;
        frame_end = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = REQ;
                    row_d   = '0;
                    plane_d = '0;
                end
            end
            REQ: begin
                if (req_valid_q && m_req_ready) state_d = SHIFT;
            end
            SHIFT: begin
                if (shift_done) begin
                    state_d   = DEAD;
                    tmr_load  = 1'b1;
                    tmr_value = TIMER_W'(DEAD_TICKS);
                end
            end
            DEAD: begin
                if (tmr_expire) state_d = LATCH;
            end
            LATCH: begin
                state_d   = SHOW;
                tmr_load  = 1'b1;
                tmr_value = TIMER_W'(BASE_TICKS) << plane_q;
            end
            SHOW: begin
                if (tmr_expire) begin
                    state_d = REQ;
                    if (!last_plane) begin
                        plane_d = plane_q + 1'b1;
                    end else begin
                        plane_d = '0;
                        if (!last_row) begin
                            row_d = row_q + 1'b1;
                        end else begin
                            // enable only matters here, so a frame always runs to completion
                            row_d     = '0;
                            frame_end = 1'b1;
                            if (!enable) state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        req_valid_d  = (state_d == REQ);
        blank_d      = (state_d != SHOW);
        latch_d      = (state_d == LATCH);
        busy_d       = (state_d != IDLE);
        frame_done_d = frame_end;
        addr_d       = (state_d == LATCH) ? row_q : addr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            plane_q      <= '0;
            addr_q       <= '0;
            req_valid_q  <= 1'b0;
            blank_q      <= 1'b1;
            latch_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            addr_q       <= addr_d;
            req_valid_q  <= req_valid_d;
            blank_q      <= blank_d;
            latch_q      <= latch_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign m_req_valid = req_valid_q;
    assign m_row       = row_q;
    assign m_plane     = plane_q;
    assign blank       = blank_q;
    assign latch_out   = latch_q;
    assign addr_out    = addr_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Scoreboard bench for hub75_bcm_scheduler: expected (row, plane) requests are queued,
// a shift-stage responder serves them, and a monitor checks timing and ordering.
module tb_hub75_bcm_scheduler;

    localparam int NUM_ROWS   = 32;
    localparam int BIT_PLANES = 6;
    localparam int BASE_TICKS = 8;
    localparam int DEAD_TICKS = 2;

    typedef struct {
        int row;
        int plane;
        bit last;
        int bp;
        int s;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n, enable, m_req_ready, shift_done;
    logic       m_req_valid, blank, latch_out, frame_done, busy;
    logic [4:0] m_row, addr_out;
    logic [2:0] m_plane;

    exp_t exp_q[$];
    exp_t mon_cur;
    int   checks = 0, errors = 0, shows = 0, frames = 0, gidx = 0;
    int   resp_sd = 0, resp_wait = 0;
    int   mon_vcnt = 0, mon_since = 0, mon_show = 0;
    bit   mon_hs = 0, prev_blank = 1;
    logic [4:0] prev_addr = '0;

    always #5 clk = ~clk;

    hub75_bcm_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_row       (m_row),
        .m_plane     (m_plane),
        .shift_done  (shift_done),
        .blank       (blank),
        .latch_out   (latch_out),
        .addr_out    (addr_out),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_idle(input string name, input int addr);
        logic [17:0] act, req;
        act = {m_req_valid, m_row, m_plane, blank, latch_out, addr_out, frame_done, busy};
        req = {1'b0, 5'd0, 3'd0, 1'b1, 1'b0, 5'(addr), 1'b0, 1'b0};
        check(act == req, name, int'(act), int'(req));
    endtask

    task automatic push_req(input int row, input int plane, input bit last);
        exp_t e;
        e.row   = row;
        e.plane = plane;
        e.last  = last;
        e.bp    = (gidx % 37 == 3) ? 5 : 0;
        e.s     = 1 + gidx % 3;
        gidx++;
        exp_q.push_back(e);
    endtask

    task automatic push_frame();
        for (int r = 0; r < NUM_ROWS; r++)
            for (int p = 0; p < BIT_PLANES; p++)
                push_req(r, p, (r == NUM_ROWS - 1) && (p == BIT_PLANES - 1));
    endtask

    task automatic wait_frames(input int n, input int limit);
        for (int i = 0; i < limit && frames < n; i++) @(negedge clk);
        #3;
        check(frames >= n, "frame_count_timeout", frames, n);
    endtask

    // Shift-stage model: honours per-request backpressure and shift latency,
    // and throws shift_done pulses where the scheduler must ignore them.
    initial begin
        m_req_ready = 1'b0;
        shift_done  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            shift_done  = 1'b0;
            m_req_ready = 1'b0;
            if (!reset_n) begin
                resp_sd   = 0;
                resp_wait = 0;
            end else begin
                if (resp_sd > 0) begin
                    resp_sd--;
                    if (resp_sd == 0) shift_done = 1'b1;
                end
                if (!blank || !busy) shift_done = 1'b1;
                if (m_req_valid && exp_q.size() > 0) begin
                    if (resp_wait < exp_q[0].bp) begin
                        resp_wait++;
                    end else begin
                        m_req_ready = 1'b1;
                        shift_done  = 1'b1;
                        resp_wait   = 0;
                        resp_sd     = exp_q[0].s;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                mon_hs     = 0;
                mon_vcnt   = 0;
                mon_show   = 0;
                prev_blank = 1;
                prev_addr  = '0;
            end else begin
                if (mon_hs) mon_since++;
                if (latch_out) begin
                    check(blank == 1'b1, "latch_implies_blank", blank, 1);
                    if (!mon_hs) begin
                        check(1'b0, "latch_without_request", 1, 0);
                    end else begin
                        check(mon_since == mon_cur.s + DEAD_TICKS + 1, "latch_timing",
                              mon_since, mon_cur.s + DEAD_TICKS + 1);
                        check(addr_out == 5'(mon_cur.row), "latch_addr", addr_out, mon_cur.row);
                    end
                    mon_hs = 0;
                end else if (mon_hs && !blank) begin
                    check(1'b0, "unblank_without_latch", 0, 1);
                    mon_hs = 0;
                end
                if (addr_out != prev_addr)
                    check(latch_out == 1'b1, "addr_change_outside_latch", addr_out, prev_addr);
                if (!blank) begin
                    mon_show++;
                end else if (!prev_blank) begin
                    check(mon_show == (BASE_TICKS << mon_cur.plane), "show_len",
                          mon_show, BASE_TICKS << mon_cur.plane);
                    check(frame_done == mon_cur.last, "frame_done_at_show_end",
                          frame_done, mon_cur.last);
                    shows++;
                    if (frame_done) frames++;
                    mon_show = 0;
                end else if (frame_done) begin
                    check(1'b0, "frame_done_spurious", 1, 0);
                end
                if (m_req_valid && exp_q.size() > 0) begin
                    mon_vcnt++;
                    check(m_row == 5'(exp_q[0].row) && m_plane == 3'(exp_q[0].plane), "req_row_plane",
                          m_row * 8 + m_plane, exp_q[0].row * 8 + exp_q[0].plane);
                    if (m_req_ready) begin
                        check(mon_vcnt == exp_q[0].bp + 1, "handshake_cycle", mon_vcnt, exp_q[0].bp + 1);
                        mon_cur   = exp_q.pop_front();
                        mon_vcnt  = 0;
                        mon_hs    = 1;
                        mon_since = 0;
                    end
                end
                prev_blank = blank;
                prev_addr  = addr_out;
            end
        end
    end

    initial begin
        #1500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check_idle("reset_hold", 0);
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            #3;
            check_idle("idle_enable_low", 0);
        end

        // Two frames; enable drops at row 10 of the second, which must still complete.
        push_frame();
        push_frame();
        enable = 1'b1;
        wait_frames(1, 40000);
        check(shows == NUM_ROWS * BIT_PLANES, "shows_per_frame", shows, NUM_ROWS * BIT_PLANES);
        for (int i = 0; i < 40000 && !(m_req_valid && m_row == 5'd10); i++) begin
            @(negedge clk);
            #3;
        end
        check(m_req_valid && m_row == 5'd10, "reach_row10", m_row, 10);
        enable = 1'b0;
        wait_frames(2, 40000);
        check(shows == 2 * NUM_ROWS * BIT_PLANES, "shows_two_frames", shows, 2 * NUM_ROWS * BIT_PLANES);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        repeat (30) begin
            @(negedge clk);
            #3;
            check_idle("idle_after_enable_drop", NUM_ROWS - 1);
        end

        // Restart, then pull reset asynchronously in the middle of a SHOW interval.
        push_frame();
        enable = 1'b1;
        for (int i = 0; i < 5000 && !(shows >= 2 * NUM_ROWS * BIT_PLANES + 2 && !blank); i++) begin
            @(negedge clk);
            #3;
        end
        check(!blank, "reached_show", blank, 0);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check_idle("async_reset_mid_show", 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #3;
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #3;
            check_idle("idle_after_async_reset", 0);
        end

        // After reset the timer must start clean: the first two shows have exact length.
        push_req(0, 0, 1'b0);
        push_req(0, 1, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 500 && shows < 2 * NUM_ROWS * BIT_PLANES + 4; i++) @(negedge clk);
        #3;
        check(shows == 2 * NUM_ROWS * BIT_PLANES + 4, "shows_after_reset",
              shows, 2 * NUM_ROWS * BIT_PLANES + 4);
        repeat (3) @(negedge clk);
        #3;
        check(m_req_valid && m_row == 5'd0 && m_plane == 3'd2, "stalled_next_req",
              {m_req_valid, m_row, m_plane}, {1'b1, 5'd0, 3'd2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
